half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder_pkg.sv | 10 +
 rtl/half_adder_cell.sv | 12 +
 rtl/half_adder.sv | 75 +++++++
 tb/tb_half_adder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared defaults and constants for the half_adder block and its lane cell.
package half_adder_pkg;

  localparam int unsigned LANES_DEF = 1;
  localparam int unsigned CNT_W_DEF = 16;

  // Wide enough for any legal counter width; callers slice the low CNT_W bits.
  localparam logic [31:0] CNT_SAT_ALL = '1;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// One combinational 1-bit half-adder lane.
module half_adder_cell (
  input  logic Bit1,
  input  logic Bit2,
  output logic Sum,
  output logic Carry
);

  assign Sum   = Bit1 ^ Bit2;
  assign Carry = Bit1 & Bit2;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// Multi-lane half adder with registered outputs, a valid flag and a
// saturating count of accepted inputs that carried in any lane.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [LANES-1:0] Bit1,
  input  logic [LANES-1:0] Bit2,
  input  logic             In_Valid,
  input  logic             Clear,
  output logic [LANES-1:0] Sum_Comb,
  output logic [LANES-1:0] Carry_Comb,
  output logic [LANES-1:0] Sum,
  output logic [LANES-1:0] Carry,
  output logic             Out_Valid,
  output logic [CNT_W-1:0] Carry_Count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_SAT_ALL[CNT_W-1:0];

  logic [LANES-1:0] sum_d,   sum_q;
  logic [LANES-1:0] carry_d, carry_q;
  logic             vld_d,   vld_q;
  logic [CNT_W-1:0] cnt_d,   cnt_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    half_adder_cell u_cell (
      .Bit1  (Bit1[g]),
      .Bit2  (Bit2[g]),
      .Sum   (Sum_Comb[g]),
      .Carry (Carry_Comb[g])
    );
  end

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    vld_d   = In_Valid;
    cnt_d   = cnt_q;
    if (In_Valid) begin
      sum_d   = Sum_Comb;
      carry_d = Carry_Comb;
    end
    // Clear wins over a same-edge increment; the count sticks at all-ones.
    if (Clear) begin
      cnt_d = '0;
    end else if (In_Valid && (|Carry_Comb) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Sum         = sum_q;
  assign Carry       = carry_q;
  assign Out_Valid   = vld_q;
  assign Carry_Count = cnt_q;

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Scoreboard bench: one single-lane/16-bit-count instance and one
// four-lane/4-bit-count instance share stimulus; lane 0 feeds the narrow one.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] b1, b2;
  logic       vld, clr;

  logic [0:0]  sca, cca, sa, ca;
  logic        ova;
  logic [15:0] cnta;
  logic [3:0]  scb, ccb, sb, cb;
  logic        ovb;
  logic [3:0]  cntb;

  always #5 clk = ~clk;

  half_adder #(.LANES(1), .CNT_W(16)) u_dut_a (
    .Clk(clk), .Rst_n(rst_n), .Bit1(b1[0]), .Bit2(b2[0]), .In_Valid(vld),
    .Clear(clr), .Sum_Comb(sca), .Carry_Comb(cca), .Sum(sa), .Carry(ca),
    .Out_Valid(ova), .Carry_Count(cnta)
  );

  half_adder #(.LANES(4), .CNT_W(4)) u_dut_b (
    .Clk(clk), .Rst_n(rst_n), .Bit1(b1), .Bit2(b2), .In_Valid(vld),
    .Clear(clr), .Sum_Comb(scb), .Carry_Comb(ccb), .Sum(sb), .Carry(cb),
    .Out_Valid(ovb), .Carry_Count(cntb)
  );

  typedef struct {
    logic        v;
    logic        sa, ca;
    logic [15:0] cnta;
    logic [3:0]  sb, cb, cntb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state: plain integers, updated from the arithmetic rules.
  logic       ma_s, ma_c;
  logic [3:0] mb_s, mb_c;
  int         ma_cnt, mb_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ma_s = 1'b0; ma_c = 1'b0; mb_s = '0; mb_c = '0;
    ma_cnt = 0; mb_cnt = 0;
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sum_a"}, 32'(sa), 32'd0);
    chk({tag, "_carry_a"}, 32'(ca), 32'd0);
    chk({tag, "_ov_a"}, 32'(ova), 32'd0);
    chk({tag, "_cnt_a"}, 32'(cnta), 32'd0);
    chk({tag, "_sum_b"}, 32'(sb), 32'd0);
    chk({tag, "_carry_b"}, 32'(cb), 32'd0);
    chk({tag, "_ov_b"}, 32'(ovb), 32'd0);
    chk({tag, "_cnt_b"}, 32'(cntb), 32'd0);
  endtask

  // Drive one cycle of stimulus, check combinational outputs, push expectation.
  task automatic step(input logic [3:0] x, input logic [3:0] y, input logic v, input logic c);
    logic [3:0] rs, rc;
    exp_t e;
    @(negedge clk);
    #2;
    b1 = x; b2 = y; vld = v; clr = c;
    #1;
    for (int i = 0; i < 4; i++) begin
      int t;
      t = int'(x[i]) + int'(y[i]);
      rs[i] = (t % 2) == 1;
      rc[i] = (t / 2) == 1;
    end
    chk("comb_sum_a", 32'(sca), 32'(rs[0]));
    chk("comb_carry_a", 32'(cca), 32'(rc[0]));
    chk("comb_sum_b", 32'(scb), 32'(rs));
    chk("comb_carry_b", 32'(ccb), 32'(rc));
    if (v) begin
      ma_s = rs[0]; ma_c = rc[0]; mb_s = rs; mb_c = rc;
    end
    if (c) ma_cnt = 0;
    else if (v && rc[0] && ma_cnt < 65535) ma_cnt++;
    if (c) mb_cnt = 0;
    else if (v && rc != 4'd0 && mb_cnt < 15) mb_cnt++;
    e.v = v; e.sa = ma_s; e.ca = ma_c; e.cnta = 16'(ma_cnt);
    e.sb = mb_s; e.cb = mb_c; e.cntb = 4'(mb_cnt);
    exp_q.push_back(e);
  endtask

  // Monitor: every falling edge, compare whatever the DUTs present.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid_a", 32'(ova), 32'(e.v));
        chk("out_valid_b", 32'(ovb), 32'(e.v));
        chk("sum_a", 32'(sa), 32'(e.sa));
        chk("carry_a", 32'(ca), 32'(e.ca));
        chk("count_a", 32'(cnta), 32'(e.cnta));
        chk("sum_b", 32'(sb), 32'(e.sb));
        chk("carry_b", 32'(cb), 32'(e.cb));
        chk("count_b", 32'(cntb), 32'(e.cntb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; b1 = '0; b2 = '0; vld = 1'b0; clr = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Truth table, back-to-back.
    step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h0, 4'h1, 1'b1, 1'b0);
    step(4'h1, 4'h0, 1'b1, 1'b0);
    step(4'h1, 4'h1, 1'b1, 1'b0);
    // Hold with In_Valid low.
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b0);
    // Multi-lane pattern: one carrying lane, count +1.
    step(4'hC, 4'hA, 1'b1, 1'b0);
    // Saturation of the 4-bit counter, then clear beats a carry.
    step(4'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step(4'hF, 4'hF, 1'b1, 1'b0);
    step(4'hF, 4'hF, 1'b1, 1'b1);
    // Clear with no valid input leaves outputs alone.
    step(4'h3, 4'h3, 1'b0, 1'b1);

    // Asynchronous reset between edges while Out_Valid is high.
    step(4'h1, 4'h1, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0; vld = 1'b0;
    #1 check_zero("midreset");
    model_reset();
    #1 rst_n = 1'b1;
    step(4'h0, 4'h1, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));
    end
    step(4'h0, 4'h0, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_half_adder
